// File: rtl/map_loader_pkg.sv
// ---------------------------------------------------------------------------
// map_loader_pkg
// Shared constants and types for the SPI map frame loader.
//   HDR_BYTE    : frame start marker
//   NUM_LINES   : number of 32-bit map lines
//   FRAME_BYTES : payload bytes per frame (4 bytes per line)
//   state_e     : sequencing states of the loader
//   byte_wr_t   : back-buffer byte write request
// ---------------------------------------------------------------------------
package map_loader_pkg;

    localparam logic [7:0] HDR_BYTE    = 8'hA5;
    localparam int         NUM_LINES   = 8;
    localparam int         FRAME_BYTES = 32;
    localparam int         LINE_W      = 32;
    localparam int         MAP_W       = NUM_LINES * LINE_W;
    localparam int         IDX_W       = $clog2(FRAME_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_PEND  = 2'd3
    } state_e;

    typedef struct packed {
        logic             en;
        logic [IDX_W-1:0] idx;
        logic [7:0]       data;
    } byte_wr_t;

endpackage

// File: rtl/map_dbuf.sv
// ---------------------------------------------------------------------------
// map_dbuf
// Double buffer for the map: a back buffer filled one byte at a time and a
// front buffer that is only ever updated by a whole-frame copy.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr          : byte write into the back buffer (byte i -> line i/4,
//                 most significant byte first within the line)
//   swap        : copy back buffer to front buffer on this edge
//   front_lines : front buffer, line k at bits [32k+31:32k]
// ---------------------------------------------------------------------------
module map_dbuf
    import map_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  byte_wr_t         wr,
    input  logic             swap,
    output logic [MAP_W-1:0] front_lines
);

    logic [NUM_LINES-1:0][LINE_W-1:0] back;
    logic [NUM_LINES-1:0][LINE_W-1:0] front;

    // Byte slot inside a line: byte 0 lands at bit 24, byte 3 at bit 0,
    // i.e. low bit = 8 * (3 - i%4), which for 2-bit i%4 is just its inverse.
    logic [4:0] bit_lo;
    assign bit_lo = {~wr.idx[1:0], 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            back <= '0;
        end else if (wr.en) begin
            back[wr.idx[IDX_W-1:2]][bit_lo +: 8] <= wr.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front <= '0;
        end else if (swap) begin
            front <= back;
        end
    end

    // Only the front buffer is visible outside.
    assign front_lines = front;

endmodule

// File: rtl/map_frame_loader.sv
// ---------------------------------------------------------------------------
// map_frame_loader
// Receives map frames over SPI (header 0xA5, 32 payload bytes, XOR checksum)
// into a back buffer and presents them on map_lines only after the frame is
// verified and the display signals frame sync (mtl_irq).
// Ports:
//   clk_clk        : clock, rising edge
//   reset_reset_n  : asynchronous active-low reset
//   spi_data       : received SPI byte
//   spi_data_valid : one-cycle strobe qualifying spi_data
//   spi_cs_n       : synchronised chip select, 1 = inactive
//   mtl_irq        : one-cycle display frame-sync pulse
//   err_clr        : clears err
//   map_lines      : front map buffer, line k = bits [32k+31:32k]
//   swap_pending   : verified frame waiting for mtl_irq
//   err            : sticky, bit0 checksum error, bit1 abort/overrun
//   frame_count    : number of frames swapped, wraps
// ---------------------------------------------------------------------------
module map_frame_loader
    import map_loader_pkg::*;
(
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [7:0]       spi_data,
    input  logic             spi_data_valid,
    input  logic             spi_cs_n,
    input  logic             mtl_irq,
    input  logic             err_clr,
    output logic [MAP_W-1:0] map_lines,
    output logic             swap_pending,
    output logic [1:0]       err,
    output logic [7:0]       frame_count
);

    state_e           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [7:0]       csum, csum_n;
    logic [1:0]       err_set;
    logic             swap;
    byte_wr_t         wr;

    // ---------------------------------------------------------------------
    // Next-state / datapath control
    // ---------------------------------------------------------------------
    always_comb begin
        state_n = state;
        idx_n   = idx;
        csum_n  = csum;
        err_set = 2'b00;
        swap    = 1'b0;
        wr.en   = 1'b0;
        wr.idx  = idx;
        wr.data = spi_data;

        case (state)
            ST_IDLE: begin
                if (spi_data_valid && spi_data == HDR_BYTE) begin
                    state_n = ST_LOAD;
                    idx_n   = '0;
                    csum_n  = 8'h00;
                end
            end

            ST_LOAD: begin
                // Deselect takes priority over a byte arriving in the same cycle.
                if (spi_cs_n) begin
                    err_set[1] = 1'b1;
                    state_n    = ST_IDLE;
                end else if (spi_data_valid) begin
                    wr.en  = 1'b1;
                    csum_n = csum ^ spi_data;
                    idx_n  = idx + 1'b1;
                    if (idx == IDX_W'(FRAME_BYTES - 1)) begin
                        state_n = ST_CHECK;
                    end
                end
            end

            ST_CHECK: begin
                if (spi_cs_n) begin
                    err_set[1] = 1'b1;
                    state_n    = ST_IDLE;
                end else if (spi_data_valid) begin
                    if (spi_data == csum) begin
                        state_n = ST_PEND;
                    end else begin
                        // Front buffer is untouched; the bad frame simply dies here.
                        err_set[0] = 1'b1;
                        state_n    = ST_IDLE;
                    end
                end
            end

            ST_PEND: begin
                // Nothing can be accepted until the verified frame is shown.
                if (spi_data_valid) begin
                    err_set[1] = 1'b1;
                end
                // An irq coinciding with the checksum byte arrives while the
                // state is still CHECK, so it is naturally not honoured.
                if (mtl_irq) begin
                    swap    = 1'b1;
                    state_n = ST_IDLE;
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= ST_IDLE;
            idx   <= '0;
            csum  <= 8'h00;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            csum  <= csum_n;
        end
    end

    // Error events beat a simultaneous clear.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            err <= 2'b00;
        end else begin
            err <= (err_clr ? 2'b00 : err) | err_set;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            frame_count <= 8'h00;
        end else if (swap) begin
            frame_count <= frame_count + 8'h01;
        end
    end

    assign swap_pending = (state == ST_PEND);

    // ---------------------------------------------------------------------
    // Buffers
    // ---------------------------------------------------------------------
    map_dbuf u_dbuf (
        .clk         (clk_clk),
        .rst_n       (reset_reset_n),
        .wr          (wr),
        .swap        (swap),
        .front_lines (map_lines)
    );

endmodule
